// File: rtl/simple_axi_slave_mem.sv
// AXI4 memory-mapped responder over an internal 64-bit RAM.
// Independent single-outstanding read and write engines; FIXED/INCR bursts, OKAY/SLVERR/DECERR.
module simple_axi_slave_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic [7:0]  s_axi_awlen,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    output logic        s_axi_bvalid,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_bready,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic [7:0]  s_axi_arlen,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arqos,
    output logic        s_axi_rvalid,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    input  logic        s_axi_rready
);
    // state   | meaning
    // W_IDLE  | waiting for AW, awready high
    // W_DATA  | accepting W beats until wlast
    // W_RESP  | presenting accumulated BRESP until bready
    // R_IDLE  | waiting for AR, arready high
    // R_FETCH | registered RAM read of the current beat
    // R_DATA  | presenting one R beat until rready

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN        = 33'(DEPTH_WORDS) * 33'd8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return {1'b0, off} < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 3);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size);
        logic [31:0] step;
        step = 32'd1 << size;
        return (a & ~(step - 32'd1)) + step;
    endfunction

    function automatic logic txn_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        return (size > 3'd3) || (burst == BURST_WRAP) || (burst == 2'b11) ||
               ((burst == BURST_FIXED) && (len != 8'd0));
    endfunction

    // Response encodings are ordered by severity, so the numeric max is the worst.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [63:0] mem [DEPTH_WORDS];

    w_state_t    w_state, w_state_nxt;
    logic [31:0] w_addr;
    logic [2:0]  w_size;
    logic [7:0]  w_len;
    logic [7:0]  w_cnt;
    logic        w_over;
    logic        w_txn_err;
    logic [1:0]  w_resp;
    logic [1:0]  w_beat_resp;
    logic        aw_hs, w_hs, w_we;

    r_state_t    r_state, r_state_nxt;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic        r_txn_err;
    logic        r_last;
    logic [1:0]  r_beat_resp;
    logic        ar_hs, r_hs;

    logic unused_attr;
    assign unused_attr = ^{s_axi_awcache, s_axi_awprot, s_axi_awlock, s_axi_awqos,
                           s_axi_arcache, s_axi_arprot, s_axi_arlock, s_axi_arqos};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = !i_rst;
                if (s_axi_awvalid && !i_rst) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = !i_rst;
                if (s_axi_wvalid && s_axi_wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = !i_rst;
                if (s_axi_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign s_axi_bresp = w_resp;

    always_comb begin
        w_beat_resp = w_txn_err ? RESP_SLVERR : RESP_OKAY;
        if (!in_range(w_addr)) w_beat_resp = worst(w_beat_resp, RESP_DECERR);
        if (w_over) w_beat_resp = worst(w_beat_resp, RESP_SLVERR);
        if (s_axi_wlast && !w_over && (w_cnt != w_len))
            w_beat_resp = worst(w_beat_resp, RESP_SLVERR);
    end

    assign w_we = w_hs && (w_beat_resp == RESP_OKAY);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_addr    <= '0;
            w_size    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_over    <= 1'b0;
            w_txn_err <= 1'b0;
            w_resp    <= RESP_OKAY;
        end else if (aw_hs) begin
            w_addr    <= s_axi_awaddr;
            w_size    <= s_axi_awsize;
            w_len     <= s_axi_awlen;
            w_cnt     <= '0;
            w_over    <= 1'b0;
            w_txn_err <= txn_bad(s_axi_awsize, s_axi_awburst, s_axi_awlen);
            w_resp    <= RESP_OKAY;
        end else if (w_hs) begin
            w_resp <= worst(w_resp, w_beat_resp);
            w_addr <= next_addr(w_addr, w_size);
            w_cnt  <= w_cnt + 8'd1;
            if (!s_axi_wlast && (w_cnt == w_len)) w_over <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int i = 0; i < 8; i++) begin
                if (s_axi_wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    assign r_last = (r_cnt == r_len);

    always_comb begin
        r_state_nxt   = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = !i_rst;
                if (s_axi_arvalid && !i_rst) r_state_nxt = R_FETCH;
            end
            R_FETCH: r_state_nxt = R_DATA;
            R_DATA: begin
                s_axi_rvalid = !i_rst;
                if (s_axi_rready) r_state_nxt = r_last ? R_IDLE : R_FETCH;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign r_hs        = s_axi_rvalid && s_axi_rready;
    assign s_axi_rlast = s_axi_rvalid && r_last;

    always_comb begin
        r_beat_resp = r_txn_err ? RESP_SLVERR : RESP_OKAY;
        if (!in_range(r_addr)) r_beat_resp = worst(r_beat_resp, RESP_DECERR);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_size      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_txn_err   <= 1'b0;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                r_addr    <= s_axi_araddr;
                r_size    <= s_axi_arsize;
                r_len     <= s_axi_arlen;
                r_cnt     <= '0;
                r_txn_err <= txn_bad(s_axi_arsize, s_axi_arburst, s_axi_arlen);
            end
            if (r_state == R_FETCH) begin
                s_axi_rresp <= r_beat_resp;
                s_axi_rdata <= (r_beat_resp == RESP_OKAY) ? mem[word_idx(r_addr)] : 64'h0;
            end
            if (r_hs && !r_last) begin
                r_addr <= next_addr(r_addr, r_size);
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/simple_axi_slave_mem.md
# simple_axi_slave_mem

AXI4 memory-mapped responder backed by an internal 64-bit-wide RAM. It is the target-side counterpart of the host-bus AXI initiator. It serves as a simulation and integration target and as on-chip scratch memory. It accepts single-beat and INCR burst transactions on independent read and write channels, applies WSTRB byte enables, and reports OKAY/SLVERR/DECERR.

## Interface
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be 8-byte aligned
- DEPTH_WORDS, 1024, number of 64-bit words; decoded range is [ADDR_BASE, ADDR_BASE + 8*DEPTH_WORDS)
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- s_axi_awvalid / s_axi_awready  in / out  1 / 1  write address handshake
- s_axi_awaddr, s_axi_awsize, s_axi_awburst, s_axi_awlen  in  32, 3, 2, 8  write address attributes
- s_axi_awcache, s_axi_awprot, s_axi_awlock, s_axi_awqos  in  4, 3, 1, 4  accepted and ignored
- s_axi_wvalid / s_axi_wready  in / out  1 / 1  write data handshake
- s_axi_wdata, s_axi_wstrb, s_axi_wlast  in  64, 8, 1  write beat
- s_axi_bvalid, s_axi_bresp / s_axi_bready  out, out / in  1, 2 / 1  write response
- s_axi_arvalid / s_axi_arready  in / out  1 / 1  read address handshake
- s_axi_araddr, s_axi_arsize, s_axi_arburst, s_axi_arlen  in  32, 3, 2, 8  read address attributes
- s_axi_arcache, s_axi_arprot, s_axi_arlock, s_axi_arqos  in  4, 3, 1, 4  accepted and ignored
- s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast / s_axi_rready  out / in  1, 64, 2, 1 / 1  read data

## Operation
- Write and read engines are independent FSMs. Each allows one outstanding transaction.
- Write FSM states:
  - W_IDLE: awready=1. On AW handshake, latch addr, size, burst and len, clear the error accumulator, and go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write each byte lane i with wstrb[i]=1 into mem[(addr-ADDR_BASE)>>3], provided the beat is legal. Then advance addr. On a beat with wlast=1, go to W_RESP.
  - W_RESP: bvalid=1 with the accumulated bresp. On bready, go to W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1. On AR handshake, latch attributes and go to R_FETCH.
  - R_FETCH: registered RAM read of the current word into rdata. Go to R_DATA.
  - R_DATA: rvalid=1 and rlast=(beat==len). On rready, if rlast go to R_IDLE; else advance addr and go to R_FETCH.
- Beat address advance: next = (addr & ~(2^size-1)) + 2^size. Arithmetic is 32-bit modulo. Narrow transfers return/accept the full 64-bit word; lane selection is by address (the initiator shifts).
- Error checks, per transaction:
  - size>3 → SLVERR.
  - burst==WRAP or reserved(3) → SLVERR.
  - burst==FIXED with len≠0 → SLVERR.
- Error checks, per beat: address outside the decoded range → DECERR.
- On any error, writes are suppressed for the affected beats and read data is 64'h0.
- BRESP reports the worst error over all beats: DECERR > SLVERR > OKAY. RRESP is reported per beat.
- WLAST is authoritative for write termination:
  - wlast earlier than len+1 beats → SLVERR, and the transaction ends.
  - No wlast at beat len → the FSM keeps accepting beats as SLVERR, with writes suppressed, until wlast.
- Same-cycle write and R_FETCH to the same word: the read returns the pre-write data.
- RAM contents are not reset.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rdata=0, rresp=0, rlast=0.
- Both FSMs go to IDLE on reset. Reset mid-burst abandons the transaction with no response.
- awready/arready are 1 from the first cycle after i_rst deasserts.
- Write latency:
  - AW handshake at cycle N → wready=1 at N+1.
  - Last W handshake at cycle M → bvalid=1 at M+1.
  - Minimum single beat: AW at N, W at N+1, B at N+2.
- Read latency:
  - AR handshake at cycle N → rvalid=1 at N+2.
  - Each further beat adds 2 cycles (R_FETCH bubble).
  - Single beat with rready held high: R handshake at N+2, arready=1 again at N+3.
- Valid/ready rules:
  - Once asserted, bvalid/rvalid and their payloads hold until the handshake.
  - awready/arready are never 1 outside IDLE.
  - wready is 0 in W_IDLE, so W data presented before AW waits.

## Test plan
- Single-beat write, then read: AW 0x10, size 3, data 0x1122334455667788, strb 0xFF → BRESP OKAY at N+2. Read 0x10 → rdata 0x1122334455667788, RRESP OKAY, rlast=1, rvalid at N+2.
- Byte strobe: write 0xAB<<24 to 0x13, size 0, strb 0x08, over a prefilled word of 0 → word reads back 0x00000000AB000000.
- INCR burst: len 3, size 3 at 0x100 writing 1,2,3,4. Read back with rready toggled 1-0-1-0 → four beats 1..4, rlast only on the 4th, payload stable across stalls.
- Decode errors:
  - Write to ADDR_BASE + 8*DEPTH_WORDS → BRESP DECERR, RAM unchanged.
  - Read crossing the top (len 1, last word) → RRESP OKAY then DECERR with rdata 0.
- Protocol errors:
  - WRAP burst → SLVERR, no write.
  - wlast on beat 1 of len 3 → BRESP SLVERR, FSM back in W_IDLE, next transaction OKAY.
- Concurrency and reset:
  - Simultaneous write and read of the same word → read returns old data.
  - i_rst asserted mid read burst → rvalid=0 next cycle, arready=1 after release.
